// File: rtl/pacman_pkg.sv
// Shared encodings for the Pac-Man direction input path: directions,
// keypad codes, PS/2 scan codes and the keypad code map.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_st_e;

  typedef struct packed {
    logic hit;
    dir_e dir;
  } dir_evt_t;

  localparam logic [4:0] KP_UP    = 5'h04;
  localparam logic [4:0] KP_DOWN  = 5'h09;
  localparam logic [4:0] KP_LEFT  = 5'h08;
  localparam logic [4:0] KP_RIGHT = 5'h0A;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;
  localparam logic [7:0] PS2_W     = 8'h1D;
  localparam logic [7:0] PS2_S     = 8'h1B;
  localparam logic [7:0] PS2_A     = 8'h1C;
  localparam logic [7:0] PS2_D     = 8'h23;

  function automatic dir_evt_t kp_map(input logic [4:0] code);
    dir_evt_t r;
    r.hit = 1'b1;
    r.dir = DIR_UP;
    case (code)
      KP_UP:    r.dir = DIR_UP;
      KP_DOWN:  r.dir = DIR_DOWN;
      KP_LEFT:  r.dir = DIR_LEFT;
      KP_RIGHT: r.dir = DIR_RIGHT;
      default:  r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dir_arbiter_if.sv
// Keypad/PS/2 inputs and the granted-direction handshake of dir_arbiter.
interface dir_arbiter_if;
  import pacman_pkg::*;

  logic [4:0] key_code;
  logic       key_ready;
  logic [7:0] ps2_byte;
  logic       ps2_ready;
  dir_e       dir;
  logic       dir_src;
  logic       dir_valid;
  logic       dir_ready;
  logic       ovf;

  modport master (
    output key_code, key_ready, ps2_byte, ps2_ready, dir_ready,
    input  dir, dir_src, dir_valid, ovf
  );

  modport slave (
    input  key_code, key_ready, ps2_byte, ps2_ready, dir_ready,
    output dir, dir_src, dir_valid, ovf
  );
endinterface

// File: rtl/ps2_dir_decode.sv
// PS/2 scan-byte decoder: tracks E0/F0 prefixes, emits a one-cycle direction
// event on make codes and drops a stale prefix after TMO_CYCLES idle cycles.
module ps2_dir_decode
  import pacman_pkg::*;
#(
  parameter int TMO_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ps2_byte_i,
  input  logic       ps2_ready_i,
  output logic       evt_o,
  output dir_e       dir_o
);

  localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

  ps2_st_e       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_prev_q, arm_q;
  logic          stb;

  // A level already high out of reset is not a byte: arm only after a low.
  assign stb = ps2_ready_i & ~rdy_prev_q & arm_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      rdy_prev_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      rdy_prev_q <= ps2_ready_i;
      arm_q      <= arm_q | ~ps2_ready_i;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    evt_o = 1'b0;
    dir_o = DIR_UP;
    if (stb) begin
      st_d = ST_IDLE;
      case (st_q)
        ST_IDLE: begin
          case (ps2_byte_i)
            PS2_EXT: st_d = ST_EXT;
            PS2_BRK: st_d = ST_BRK;
            PS2_W:   begin evt_o = 1'b1; dir_o = DIR_UP;    end
            PS2_S:   begin evt_o = 1'b1; dir_o = DIR_DOWN;  end
            PS2_A:   begin evt_o = 1'b1; dir_o = DIR_LEFT;  end
            PS2_D:   begin evt_o = 1'b1; dir_o = DIR_RIGHT; end
            default: ;
          endcase
        end
        ST_EXT: begin
          case (ps2_byte_i)
            PS2_BRK:   st_d = ST_EXT_BRK;
            PS2_UP:    begin evt_o = 1'b1; dir_o = DIR_UP;    end
            PS2_DOWN:  begin evt_o = 1'b1; dir_o = DIR_DOWN;  end
            PS2_LEFT:  begin evt_o = 1'b1; dir_o = DIR_LEFT;  end
            PS2_RIGHT: begin evt_o = 1'b1; dir_o = DIR_RIGHT; end
            default:   ;
          endcase
        end
        default: ; // break code byte is swallowed
      endcase
    end else if (st_q != ST_IDLE) begin
      if (cnt_q == CW'(TMO_CYCLES - 1)) st_d = ST_IDLE;
      else                               cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dir_arbiter.sv
// Merges keypad and PS/2 direction events into one valid/ready stream:
// one pending slot per source, round-robin on contention, latest-wins overwrite.
module dir_arbiter
  import pacman_pkg::*;
#(
  parameter int TMO_CYCLES = 1000000
) (
  input logic          clk,
  input logic          clrn,
  dir_arbiter_if.slave bus
);

  logic [4:0] kcode_s1_q, kcode_s2_q;
  logic       krdy_s1_q, krdy_s2_q, krdy_prev_q, karm_q;
  logic [1:0] ksync_vld_q;
  dir_evt_t   kmap;
  logic       kev, pev;
  dir_e       pdir;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      kcode_s1_q  <= '0;
      kcode_s2_q  <= '0;
      krdy_s1_q   <= 1'b0;
      krdy_s2_q   <= 1'b0;
      krdy_prev_q <= 1'b0;
      karm_q      <= 1'b0;
      ksync_vld_q <= '0;
    end else begin
      kcode_s1_q  <= bus.key_code;
      kcode_s2_q  <= kcode_s1_q;
      krdy_s1_q   <= bus.key_ready;
      krdy_s2_q   <= krdy_s1_q;
      krdy_prev_q <= krdy_s2_q;
      ksync_vld_q <= {ksync_vld_q[0], 1'b1};
      // Arm only on a genuine low, not on the reset-cleared synchronizer.
      karm_q      <= karm_q | (ksync_vld_q[1] & ~krdy_s2_q);
    end
  end

  assign kmap = kp_map(kcode_s2_q);
  assign kev  = krdy_s2_q & ~krdy_prev_q & karm_q & kmap.hit;

  ps2_dir_decode #(.TMO_CYCLES(TMO_CYCLES)) u_ps2 (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_byte_i (bus.ps2_byte),
    .ps2_ready_i(bus.ps2_ready),
    .evt_o      (pev),
    .dir_o      (pdir)
  );

  logic kslot_vld_q, kslot_vld_d, pslot_vld_q, pslot_vld_d;
  dir_e kslot_dir_q, kslot_dir_d, pslot_dir_q, pslot_dir_d;
  logic vld_q, vld_d, src_q, src_d, ovf_q, ovf_d, prio_ps2_q, prio_ps2_d;
  dir_e dir_q, dir_d;
  logic load, grant_k, grant_p;

  assign load = ~vld_q | bus.dir_ready;

  always_comb begin
    grant_k = 1'b0;
    grant_p = 1'b0;
    if (load) begin
      if (kslot_vld_q && pslot_vld_q) begin
        grant_p = prio_ps2_q;
        grant_k = ~prio_ps2_q;
      end else begin
        grant_k = kslot_vld_q;
        grant_p = pslot_vld_q;
      end
    end
  end

  always_comb begin
    kslot_vld_d = kslot_vld_q & ~grant_k;
    kslot_dir_d = kslot_dir_q;
    pslot_vld_d = pslot_vld_q & ~grant_p;
    pslot_dir_d = pslot_dir_q;
    if (kev) begin
      kslot_vld_d = 1'b1;
      kslot_dir_d = kmap.dir;
    end
    if (pev) begin
      pslot_vld_d = 1'b1;
      pslot_dir_d = pdir;
    end
    // A slot being granted this cycle is refilled, not overwritten.
    ovf_d = (kev & kslot_vld_q & ~grant_k) | (pev & pslot_vld_q & ~grant_p);

    vld_d      = vld_q;
    dir_d      = dir_q;
    src_d      = src_q;
    prio_ps2_d = prio_ps2_q;
    if (load) begin
      vld_d = grant_k | grant_p;
      if (grant_k) begin
        dir_d      = kslot_dir_q;
        src_d      = 1'b0;
        prio_ps2_d = 1'b1;
      end else if (grant_p) begin
        dir_d      = pslot_dir_q;
        src_d      = 1'b1;
        prio_ps2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      kslot_vld_q <= 1'b0;
      kslot_dir_q <= DIR_UP;
      pslot_vld_q <= 1'b0;
      pslot_dir_q <= DIR_UP;
      vld_q       <= 1'b0;
      dir_q       <= DIR_UP;
      src_q       <= 1'b0;
      ovf_q       <= 1'b0;
      prio_ps2_q  <= 1'b0;
    end else begin
      kslot_vld_q <= kslot_vld_d;
      kslot_dir_q <= kslot_dir_d;
      pslot_vld_q <= pslot_vld_d;
      pslot_dir_q <= pslot_dir_d;
      vld_q       <= vld_d;
      dir_q       <= dir_d;
      src_q       <= src_d;
      ovf_q       <= ovf_d;
      prio_ps2_q  <= prio_ps2_d;
    end
  end

  assign bus.dir       = dir_q;
  assign bus.dir_src   = src_q;
  assign bus.dir_valid = vld_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dir_arbiter.sv
// Directed-vector bench for dir_arbiter with hand-computed expectations.
module tb_dir_arbiter;
  import pacman_pkg::*;

  localparam int TMO = 16;

  logic clk, clrn;
  int   vec_cnt = 0, miss_cnt = 0;
  int   ovf_seen = 0, vld_seen = 0;

  dir_arbiter_if bus ();

  dir_arbiter #(.TMO_CYCLES(TMO)) dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ovf)       ovf_seen++;
    if (bus.dir_valid) vld_seen++;
  end

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Strobe one byte, then drop ready so the next byte makes a fresh edge.
  task automatic ps2_send(input logic [7:0] b);
    bus.ps2_byte  = b;
    bus.ps2_ready = 1'b1;
    tick();
    bus.ps2_ready = 1'b0;
    tick();
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] d, input logic s);
    check_vec({tag, "_valid"}, bus.dir_valid, v);
    if (v) begin
      check_vec({tag, "_dir"}, bus.dir, d);
      check_vec({tag, "_src"}, bus.dir_src, s);
    end
  endtask

  initial begin
    int v0, o0;
    clrn          = 1'b0;
    bus.key_code  = '0;
    bus.key_ready = 1'b0;
    bus.ps2_byte  = '0;
    bus.ps2_ready = 1'b0;
    bus.dir_ready = 1'b1;
    #12;
    check_vec("rst_valid", bus.dir_valid, 0);
    check_vec("rst_dir", bus.dir, 0);
    check_vec("rst_src", bus.dir_src, 0);
    check_vec("rst_ovf", bus.ovf, 0);
    clrn = 1'b1;
    idle(4);

    // E0 75: extended up arrow, visible two cycles after the 75 edge
    ps2_send(8'hE0);
    check_vec("e0_noevt", bus.dir_valid, 0);
    ps2_send(8'h75);
    check_out("ext_up", 1'b1, 2'd0, 1'b1);
    tick();
    check_vec("ext_up_pulse", bus.dir_valid, 0);

    // F0 1C is a release, 1B afterwards is a fresh down
    ps2_send(8'hF0);
    ps2_send(8'h1C);
    check_vec("brk_noevt", bus.dir_valid, 0);
    ps2_send(8'h1B);
    check_out("after_brk", 1'b1, 2'd1, 1'b1);
    tick();

    // unmapped keypad code is dropped
    bus.key_code  = 5'h05;
    bus.key_ready = 1'b1;
    idle(6);
    check_vec("kp_unmapped", bus.dir_valid, 0);
    bus.key_ready = 1'b0;
    idle(4);

    // keypad latency: valid four cycles after key_ready is presented
    bus.key_code  = 5'h09;
    bus.key_ready = 1'b1;
    idle(3);
    check_vec("kp_lat3", bus.dir_valid, 0);
    tick();
    check_out("kp_lat4", 1'b1, 2'd1, 1'b0);
    bus.key_ready = 1'b0;
    tick();
    check_vec("kp_pulse", bus.dir_valid, 0);
    idle(4);

    // contention after a keypad grant: PS/2 wins first
    bus.key_code  = 5'h0A;
    bus.key_ready = 1'b1;
    idle(2);
    bus.ps2_byte  = 8'h1C;
    bus.ps2_ready = 1'b1;
    tick();
    bus.ps2_ready = 1'b0;
    tick();
    check_out("rr_first", 1'b1, 2'd2, 1'b1);
    tick();
    check_out("rr_second", 1'b1, 2'd3, 1'b0);
    tick();
    check_vec("rr_drain", bus.dir_valid, 0);
    bus.key_ready = 1'b0;
    idle(4);

    // stalled output, PS/2 slot overwritten, then refill in the grant cycle
    bus.dir_ready = 1'b0;
    o0 = ovf_seen;
    ps2_send(8'h1C);
    check_out("hold_load", 1'b1, 2'd2, 1'b1);
    ps2_send(8'h1D);
    ps2_send(8'h1B);
    check_vec("ovf_once", ovf_seen - o0, 1);
    check_out("hold_stable", 1'b1, 2'd2, 1'b1);
    bus.dir_ready = 1'b1;
    bus.ps2_byte  = 8'h23;
    bus.ps2_ready = 1'b1;
    tick();
    bus.ps2_ready = 1'b0;
    check_out("latest_wins", 1'b1, 2'd1, 1'b1);
    tick();
    check_out("refill", 1'b1, 2'd3, 1'b1);
    tick();
    check_vec("refill_drain", bus.dir_valid, 0);
    check_vec("refill_no_ovf", ovf_seen - o0, 1);

    // stale E0 times out, so 74 lands in IDLE and is ignored
    v0 = vld_seen;
    ps2_send(8'hE0);
    idle(TMO + 4);
    ps2_send(8'h74);
    tick();
    check_vec("tmo_drop", vld_seen - v0, 0);
    ps2_send(8'hE0);
    ps2_send(8'h74);
    check_out("ext_right", 1'b1, 2'd3, 1'b1);
    tick();

    // after reset keypad wins a same-cycle tie
    clrn = 1'b0;
    #2;
    clrn = 1'b1;
    idle(4);
    bus.key_code  = 5'h08;
    bus.key_ready = 1'b1;
    idle(2);
    bus.ps2_byte  = 8'h23;
    bus.ps2_ready = 1'b1;
    tick();
    bus.ps2_ready = 1'b0;
    tick();
    check_out("tie_kp", 1'b1, 2'd2, 1'b0);
    tick();
    check_out("tie_ps2", 1'b1, 2'd3, 1'b1);
    tick();
    check_vec("tie_drain", bus.dir_valid, 0);
    bus.key_ready = 1'b0;
    idle(4);

    // reset while holding a command with keypad and PS/2 levels still high
    bus.dir_ready = 1'b0;
    bus.key_code  = 5'h0A;
    bus.key_ready = 1'b1;
    idle(4);
    check_out("pre_rst_hold", 1'b1, 2'd3, 1'b0);
    bus.ps2_byte  = 8'h1D;
    bus.ps2_ready = 1'b1;
    tick();
    clrn = 1'b0;
    #1;
    check_vec("arst_valid", bus.dir_valid, 0);
    check_vec("arst_dir", bus.dir, 0);
    check_vec("arst_src", bus.dir_src, 0);
    check_vec("arst_ovf", bus.ovf, 0);
    #2;
    clrn = 1'b1;
    bus.dir_ready = 1'b1;
    v0 = vld_seen;
    idle(10);
    check_vec("no_replay", vld_seen - v0, 0);
    bus.key_ready = 1'b0;
    bus.ps2_ready = 1'b0;
    idle(4);
    bus.key_ready = 1'b1;
    idle(4);
    check_out("repress", 1'b1, 2'd3, 1'b0);
    bus.key_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
